mu0_control: RTL and testbench
==============================

MU0_CONTROL -- requirements
Module: mu0_control

Interface
REQ-001 The block SHALL have no parameters; all encodings come from mu0_pkg.
REQ-002 The ports SHALL be:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- F  in  4  opcode, IR[15:12]
- N  in  1  ACC negative flag (ACC[15])
- Z  in  1  ACC zero flag
- Mem_Rdy  in  1  memory ready; used only with MU0_MEM_WAIT_EN
- X_sel  out  1  ALU X source: 0 = ACC, 1 = PC
- Y_sel  out  1  ALU Y source: 0 = memory data, 1 = IR[11:0]
- Addr_sel  out  1  address source: 0 = PC, 1 = IR[11:0]
- M  out  2  ALU mode: 00 pass Y, 01 X+Y, 10 X+1, 11 X-Y
- PC_En  out  1  PC load enable
- Acc_En  out  1  ACC load enable
- IR_En  out  1  IR load enable
- Rd  out  1  memory read strobe
- Wr  out  1  memory write strobe
- Halted  out  1  processor stopped

Function
REQ-003 The state machine SHALL have three states: FETCH, EXEC and HALT; the state register is the only storage.
REQ-004 Outputs SHALL decode combinationally from the state and F, N, Z (Moore/Mealy mix; no registered outputs).
REQ-005 FETCH outputs SHALL be: Addr_sel=0, Rd=1, IR_En=1, X_sel=1, M=10, PC_En=1; all other strobes 0.
REQ-006 FETCH SHALL always go to EXEC on the next edge, subject to REQ-014.
REQ-007 EXEC SHALL drive Addr_sel=1. Per opcode:
- LDA 0: Rd, Y_sel=0, M=00, Acc_En
- STA 1: Wr, X_sel=0
- ADD 2: Rd, X_sel=0, Y_sel=0, M=01, Acc_En
- SUB 3: as ADD with M=11
- JMP 4: Y_sel=1, M=00, PC_En
- JGE 5: as JMP with PC_En = ~N
- JNE 6: as JMP with PC_En = ~Z
- STP 7: no strobes
REQ-008 Opcodes 8-15 SHALL execute as NOP: no strobes, Rd=Wr=0, then FETCH.
REQ-009 EXEC SHALL go to HALT when F=7; for every other opcode it SHALL go to FETCH.
REQ-010 In HALT: Halted=1; PC_En, Acc_En, IR_En, Rd and Wr = 0; the state is held until reset.
REQ-011 Rd and Wr SHALL never both be 1 in the same cycle.
REQ-012 Every output that is unused in a state SHALL be driven to 0 (never X), including M=00 and the select lines.
REQ-013 Without wait states, each instruction SHALL take exactly 2 cycles: FETCH then EXEC.

Reset
REQ-014 While Reset_n=0, the state SHALL be FETCH immediately (asynchronously), and PC_En, Acc_En, IR_En, Rd, Wr and Halted SHALL all be 0.
REQ-015 On the first rising Clk after Reset_n rises, the block SHALL perform FETCH behaviour.
REQ-016 Reset asserted mid-EXEC or in HALT SHALL abort the instruction with no enable pulse emitted.

Configuration
REQ-017 The macro MU0_MEM_WAIT_EN, when defined, SHALL add wait-state support:
- In FETCH, and in an EXEC that accesses memory (LDA, STA, ADD, SUB), with Mem_Rdy=0: hold the state, keep Rd/Wr asserted and Addr_sel/M stable, and force PC_En, Acc_En and IR_En to 0.
- When Mem_Rdy=1, the normal enables fire and the state advances.
REQ-018 Without MU0_MEM_WAIT_EN, Mem_Rdy SHALL be ignored and the block SHALL behave as if Mem_Rdy=1.

Structure
REQ-019 mu0_pkg SHALL hold:
- the opcode enum (LDA..STP)
- the state enum (FETCH, EXEC, HALT; 2 bits)
- the ALU mode constants ALU_PASS_Y, ALU_ADD, ALU_INC, ALU_SUB
REQ-020 Opcode-to-strobe decode SHALL sit in one combinational sub-module, mu0_exec_decode; the state register and next-state logic SHALL stay in mu0_control.

Verification
REQ-021 Reset, then 2 cycles with F=0 (LDA) -> FETCH cycle shows Rd=1, IR_En=1, PC_En=1, M=10; EXEC cycle shows Addr_sel=1, Acc_En=1, M=00, Wr=0.
REQ-022 F=5 (JGE) with N=1, then with N=0 -> PC_En=0, then PC_En=1; Y_sel=1 and M=00 in both cases.
REQ-023 F=6 (JNE) with Z=1 -> PC_En=0; F=3 (SUB) -> M=11, Acc_En=1, X_sel=0.
REQ-024 F=7 -> Halted=1 from the cycle after EXEC; 10 further clocks keep all strobes 0; Reset_n low -> Halted=0 with no clock edge.
REQ-025 With MU0_MEM_WAIT_EN and Mem_Rdy=0 for 3 cycles in FETCH -> Rd=1 and IR_En=0 throughout, state held; Mem_Rdy=1 -> IR_En=1, then EXEC.
REQ-026 F=9 (illegal) -> no strobes in EXEC, next state FETCH; Reset_n pulsed low mid-EXEC of F=2 -> Acc_En=0 at once, FETCH on release.

Source files
------------

// File: rtl/mu0_pkg.sv
// mu0_pkg: shared encodings for the MU0 controller (opcodes, FSM states, ALU modes).
package mu0_pkg;

    typedef enum logic [3:0] {
        LDA = 4'd0,
        STA = 4'd1,
        ADD = 4'd2,
        SUB = 4'd3,
        JMP = 4'd4,
        JGE = 4'd5,
        JNE = 4'd6,
        STP = 4'd7
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [1:0] ALU_PASS_Y = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b01;
    localparam logic [1:0] ALU_INC    = 2'b10;
    localparam logic [1:0] ALU_SUB    = 2'b11;

    // Opcodes that touch memory during EXEC and therefore may be stretched by wait states
    function automatic logic is_mem_op(input logic [3:0] f);
        return (f == LDA) || (f == STA) || (f == ADD) || (f == SUB);
    endfunction

endpackage

// File: rtl/mu0_exec_decode.sv
// mu0_exec_decode: purely combinational opcode-to-strobe decode for the EXEC state.
// Enables are raw here; the controller gates them with memory ready and reset.
module mu0_exec_decode
    import mu0_pkg::*;
(
    input  logic [3:0] f,
    input  logic       n,
    input  logic       z,
    output logic       x_sel,
    output logic       y_sel,
    output logic [1:0] m,
    output logic       pc_en,
    output logic       acc_en,
    output logic       rd,
    output logic       wr,
    output logic       mem_op
);

    // Per-opcode strobes; anything not listed (STP, 8-15) leaves everything at 0
    always_comb begin
        x_sel  = 1'b0;
        y_sel  = 1'b0;
        m      = ALU_PASS_Y;
        pc_en  = 1'b0;
        acc_en = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        mem_op = is_mem_op(f);
        case (f)
            LDA: begin
                rd     = 1'b1;
                acc_en = 1'b1;
            end
            STA: wr = 1'b1;
            ADD: begin
                rd     = 1'b1;
                m      = ALU_ADD;
                acc_en = 1'b1;
            end
            SUB: begin
                rd     = 1'b1;
                m      = ALU_SUB;
                acc_en = 1'b1;
            end
            JMP: begin
                y_sel = 1'b1;
                pc_en = 1'b1;
            end
            JGE: begin
                y_sel = 1'b1;
                pc_en = ~n;
            end
            JNE: begin
                y_sel = 1'b1;
                pc_en = ~z;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// mu0_control: MU0 FETCH/EXEC/HALT controller. Outputs decode combinationally
// from the state and opcode/flags; the state register is the only storage.
// Optional wait-state support is enabled by defining MU0_MEM_WAIT_EN.
module mu0_control
    import mu0_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    input  logic       Mem_Rdy,
    output logic       X_sel,
    output logic       Y_sel,
    output logic       Addr_sel,
    output logic [1:0] M,
    output logic       PC_En,
    output logic       Acc_En,
    output logic       IR_En,
    output logic       Rd,
    output logic       Wr,
    output logic       Halted
);

    state_t     state;
    logic       rdy;
    logic       ex_go;
    logic       dec_x_sel, dec_y_sel, dec_pc_en, dec_acc_en, dec_rd, dec_wr, dec_mem_op;
    logic [1:0] dec_m;

`ifdef MU0_MEM_WAIT_EN
    assign rdy = Mem_Rdy;
`else
    // Memory always ready: the input is tied off logically
    assign rdy = Mem_Rdy | 1'b1;
`endif

    // Non-memory opcodes never wait, memory opcodes wait for ready
    assign ex_go = ~dec_mem_op | rdy;

    mu0_exec_decode u_dec (
        .f      (F),
        .n      (N),
        .z      (Z),
        .x_sel  (dec_x_sel),
        .y_sel  (dec_y_sel),
        .m      (dec_m),
        .pc_en  (dec_pc_en),
        .acc_en (dec_acc_en),
        .rd     (dec_rd),
        .wr     (dec_wr),
        .mem_op (dec_mem_op)
    );

    // State register with next-state logic; HALT is left only through reset
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (rdy) state <= EXEC;
                EXEC:    if (ex_go) state <= (F == STP) ? HALT : FETCH;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Output decode; enables and strobes are killed while reset is held
    always_comb begin
        X_sel    = 1'b0;
        Y_sel    = 1'b0;
        Addr_sel = 1'b0;
        M        = ALU_PASS_Y;
        PC_En    = 1'b0;
        Acc_En   = 1'b0;
        IR_En    = 1'b0;
        Rd       = 1'b0;
        Wr       = 1'b0;
        Halted   = 1'b0;
        case (state)
            FETCH: begin
                Rd    = 1'b1;
                X_sel = 1'b1;
                M     = ALU_INC;
                IR_En = rdy;
                PC_En = rdy;
            end
            EXEC: begin
                Addr_sel = 1'b1;
                X_sel    = dec_x_sel;
                Y_sel    = dec_y_sel;
                M        = dec_m;
                Rd       = dec_rd;
                Wr       = dec_wr;
                PC_En    = dec_pc_en & ex_go;
                Acc_En   = dec_acc_en & ex_go;
            end
            HALT:    Halted = 1'b1;
            default: ;
        endcase
        if (!Reset_n) begin
            PC_En  = 1'b0;
            Acc_En = 1'b0;
            IR_En  = 1'b0;
            Rd     = 1'b0;
            Wr     = 1'b0;
            Halted = 1'b0;
        end
    end

endmodule

// File: tb/tb_mu0_control.sv
// tb_mu0_control: scoreboard bench for mu0_control. Expected output vectors are
// built by a small behavioural model and queued as stimulus is driven, then
// popped and compared mid-cycle. Wait-state checks run when MU0_MEM_WAIT_EN is defined.
module tb_mu0_control;

`ifdef MU0_MEM_WAIT_EN
    localparam bit WAITS = 1'b1;
`else
    localparam bit WAITS = 1'b0;
`endif

    logic       Clk, Reset_n;
    logic [3:0] F;
    logic       N, Z, Mem_Rdy;
    logic       X_sel, Y_sel, Addr_sel, PC_En, Acc_En, IR_En, Rd, Wr, Halted;
    logic [1:0] M;

    typedef struct {
        string       tag;
        logic [10:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mst   = 0;   // model state: 0 fetch, 1 exec, 2 halt

    mu0_control dut (
        .Clk(Clk), .Reset_n(Reset_n), .F(F), .N(N), .Z(Z), .Mem_Rdy(Mem_Rdy),
        .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .M(M),
        .PC_En(PC_En), .Acc_En(Acc_En), .IR_En(IR_En), .Rd(Rd), .Wr(Wr), .Halted(Halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Vector order: {X_sel,Y_sel,Addr_sel,M[1:0],PC_En,Acc_En,IR_En,Rd,Wr,Halted}
    function automatic logic [10:0] model_out(input int st, input logic [3:0] f,
                                              input logic n, input logic z,
                                              input logic rdy, input logic rst_n);
        logic x, y, a, pc, acc, ir, rd, wr, h;
        logic [1:0] m;
        {x, y, a, pc, acc, ir, rd, wr, h} = '0;
        m = 2'b00;
        if (st == 0) begin
            x = 1; m = 2'b10; rd = 1; ir = rdy; pc = rdy;
        end else if (st == 1) begin
            a = 1;
            case (f)
                4'd0: begin rd = 1; acc = rdy; end
                4'd1: wr = 1;
                4'd2: begin rd = 1; acc = rdy; m = 2'b01; end
                4'd3: begin rd = 1; acc = rdy; m = 2'b11; end
                4'd4: begin y = 1; pc = 1; end
                4'd5: begin y = 1; pc = !n; end
                4'd6: begin y = 1; pc = !z; end
                default: ;
            endcase
        end else begin
            h = 1;
        end
        if (!rst_n) {pc, acc, ir, rd, wr, h} = '0;
        return {x, y, a, m, pc, acc, ir, rd, wr, h};
    endfunction

    function automatic int model_next(input int st, input logic [3:0] f, input logic rdy);
        if (st == 0) return rdy ? 1 : 0;
        if (st == 1) begin
            if (f <= 4'd3 && !rdy) return 1;
            return (f == 4'd7) ? 2 : 0;
        end
        return 2;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 16'd1, 16'd0);
            return;
        end
        e = sb.pop_front();
        check(e.tag, {5'd0, X_sel, Y_sel, Addr_sel, M, PC_En, Acc_En, IR_En, Rd, Wr, Halted},
              {5'd0, e.v});
        check({e.tag, "_rdwr"}, {15'd0, Rd & Wr}, 16'd0);
    endtask

    // One clock: entered #1 after a rising edge, left #1 after the next one
    task automatic cyc(input logic [3:0] f, input logic n, input logic z,
                       input logic rdy, input string tag);
        logic r;
        F = f; N = n; Z = z; Mem_Rdy = rdy;
        r = WAITS ? rdy : 1'b1;
        sb.push_back('{tag, model_out(mst, f, n, z, r, 1'b1)});
        @(negedge Clk);
        check_out();
        mst = model_next(mst, f, r);
        @(posedge Clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] f, input logic n, input logic z, input string tag);
        cyc(f, n, z, 1'b1, {tag, "_fetch"});
        cyc(f, n, z, 1'b1, tag);
    endtask

    // Assert reset without a clock edge and check the outputs respond at once
    task automatic rst_check(input string tag);
        Reset_n = 1'b0;
        #1;
        sb.push_back('{tag, model_out(0, F, N, Z, 1'b1, 1'b0)});
        check_out();
        mst = 0;
    endtask

    initial begin
        Reset_n = 1'b0; F = 4'd0; N = 1'b0; Z = 1'b0; Mem_Rdy = 1'b1;
        #3;
        rst_check("reset");
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        instr(4'd0, 0, 0, "lda");
        instr(4'd1, 0, 0, "sta");
        instr(4'd2, 0, 0, "add");
        instr(4'd3, 0, 0, "sub");
        instr(4'd4, 1, 1, "jmp");
        instr(4'd5, 1, 0, "jge_n1");
        instr(4'd5, 0, 0, "jge_n0");
        instr(4'd6, 0, 1, "jne_z1");
        instr(4'd6, 0, 0, "jne_z0");
        instr(4'd9, 1, 1, "nop9");
        instr(4'd12, 0, 0, "nop12");
        instr(4'd0, 0, 0, "lda_after_nop");

        // Mem_Rdy low: ignored in the default build, a stall with wait states
        cyc(4'd2, 0, 0, 1'b0, "add_nr_fetch");
        cyc(4'd2, 0, 0, 1'b1, "add_nr_fetch2");
        cyc(4'd2, 0, 0, 1'b0, "add_nr_exec");
        cyc(4'd2, 0, 0, 1'b1, "add_nr_exec2");
        while (mst != 0) cyc(4'd0, 0, 0, 1'b1, "drain");

`ifdef MU0_MEM_WAIT_EN
        for (int i = 0; i < 3; i++) cyc(4'd0, 0, 0, 1'b0, "wait_fetch");
        cyc(4'd0, 0, 0, 1'b1, "wait_fetch_go");
        cyc(4'd0, 0, 0, 1'b0, "wait_lda");
        cyc(4'd0, 0, 0, 1'b1, "wait_lda_go");
        cyc(4'd1, 0, 0, 1'b1, "wait_sta_fetch");
        cyc(4'd1, 0, 0, 1'b0, "wait_sta");
        cyc(4'd1, 0, 0, 1'b1, "wait_sta_go");
        cyc(4'd4, 0, 0, 1'b1, "jmp_fetch");
        cyc(4'd4, 0, 0, 1'b0, "jmp_nowait");
`endif

        // Reset pulse in the middle of an ADD execute cycle
        cyc(4'd2, 0, 0, 1'b1, "abort_fetch");
        F = 4'd2; Mem_Rdy = 1'b1;
        #2;
        rst_check("abort_exec");
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        instr(4'd0, 0, 0, "lda_after_abort");

        // Stop, then stay halted regardless of the opcode inputs
        instr(4'd7, 0, 0, "stp");
        for (int i = 0; i < 10; i++)
            cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b1, "halt");
        #2;
        rst_check("halt_reset");
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        instr(4'd3, 0, 0, "sub_after_halt");

        check("sb_drained", 16'(sb.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
